// File: rtl/axis_stall_watchdog.sv
// ---------------------------------------------------------------------------
// axis_stall_watchdog
//
// Multi-channel AXI-Stream stall watchdog. Every channel counts consecutive
// backpressure cycles (tvalid && !tready). When that count reaches the
// runtime limit, the channel raises a sticky timeout flag. The block also
// records which channel timed out first, so software can tell where a
// pipeline lockup started.
//
// Parameters
//   NUM_CH  number of monitored channels (>= 1)
//   CNT_W   stall counter width; counters saturate at all-ones
//   CH_W    width of the channel index output (derived, minimum 1)
//
// Ports
//   clk          clock; all logic is synchronous to it
//   rst          asynchronous active-high reset
//   enable       0 holds every counter idle; sticky flags keep their value
//   limit        stall limit in cycles; 0 disables the timeout
//   clear        per-channel clear of the flag and count (one-cycle pulse)
//   tvalid       monitored channel tvalid bits
//   tready       monitored channel tready bits
//   timeout      sticky per-channel timeout flags
//   timeout_any  OR of the timeout flags, registered together with them
//   first_vld    first_ch holds a valid capture
//   first_ch     lowest-index channel among the earliest timeouts
//   stall_cnt    live per-channel stall counts, channel 0 in the LSBs
// ---------------------------------------------------------------------------
module axis_stall_watchdog #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        limit,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       tvalid,
  input  logic [NUM_CH-1:0]       tready,
  output logic [NUM_CH-1:0]       timeout,
  output logic                    timeout_any,
  output logic                    first_vld,
  output logic [CH_W-1:0]         first_ch,
  output logic [NUM_CH*CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_TMO   = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_inc [NUM_CH];
  logic [NUM_CH-1:0] timeout_d;
  logic [NUM_CH-1:0] rise;
  logic [CH_W-1:0]   rise_idx;

  // The incremented count never wraps. If a limit is lowered below the
  // current count mid-stall, that stall can then never match the limit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
    end
  end

  // Per-channel next state.
  // Priority order: clear, then disable, then normal FSM operation.
  // clear beats a timeout that would fire on the same edge.
  always_comb begin
    timeout_d = timeout;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear[i]) begin
        state_d[i]   = ST_IDLE;
        cnt_d[i]     = '0;
        timeout_d[i] = 1'b0;
      end else if (!enable) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (tvalid[i] && !tready[i]) begin
              cnt_d[i] = CNT_ONE;
              if (limit == CNT_ONE) begin
                state_d[i]   = ST_TMO;
                timeout_d[i] = 1'b1;
              end else begin
                state_d[i] = ST_STALL;
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
          ST_STALL: begin
            if (tvalid[i] && !tready[i]) begin
              cnt_d[i] = cnt_inc[i];
              if ((limit != '0) && (cnt_inc[i] == limit)) begin
                state_d[i]   = ST_TMO;
                timeout_d[i] = 1'b1;
              end
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end
          ST_TMO: begin
            state_d[i] = ST_TMO;
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Find the flags that rise on this edge.
  // Descending scan, so the lowest rising index wins.
  always_comb begin
    rise     = timeout_d & ~timeout;
    rise_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = CH_W'(i);
      end
    end
  end

  // State, count and flag registers.
  // The first-timeout capture is released one edge after every flag has
  // cleared. Captures occur only while no capture is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      timeout     <= '0;
      timeout_any <= 1'b0;
      first_vld   <= 1'b0;
      first_ch    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      timeout     <= timeout_d;
      timeout_any <= |timeout_d;
      if (first_vld && (timeout == '0)) begin
        first_vld <= 1'b0;
        first_ch  <= '0;
      end else if (!first_vld && (rise != '0)) begin
        first_vld <= 1'b1;
        first_ch  <= rise_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign stall_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_axis_stall_watchdog.sv
// ---------------------------------------------------------------------------
// tb_axis_stall_watchdog
//
// Scoreboard bench for axis_stall_watchdog.
// - Stimulus issues one input vector per clock. After each edge it updates a
//   behavioural model and pushes the expected outputs into a queue.
// - A monitor on the falling edge pops each entry and compares it with the
//   DUT outputs.
// - The model tracks each channel's run length of stalled samples with plain
//   integers.
// - A second instance with a 4-bit counter covers saturation.
// ---------------------------------------------------------------------------
module tb_axis_stall_watchdog;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [31:0]   limit;
  logic [3:0]    clear;
  logic [3:0]    tvalid;
  logic [3:0]    tready;
  logic [3:0]    timeout;
  logic          timeout_any;
  logic          first_vld;
  logic [1:0]    first_ch;
  logic [127:0]  stall_cnt;

  logic          s_enable;
  logic [3:0]    s_limit;
  logic [0:0]    s_clear;
  logic [0:0]    s_tvalid;
  logic [0:0]    s_tready;
  logic [0:0]    s_timeout;
  logic          s_timeout_any;
  logic          s_first_vld;
  logic [0:0]    s_first_ch;
  logic [3:0]    s_stall_cnt;

  typedef struct packed {
    logic [3:0]   tmo;
    logic         any;
    logic         fvld;
    logic [1:0]   fch;
    logic [127:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  longint    m_run [4];
  logic [3:0] m_tmo;
  logic [3:0] m_frz;
  logic      m_fvld;
  logic [1:0] m_fch;

  always #5 clk = ~clk;

  axis_stall_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .limit(limit), .clear(clear),
    .tvalid(tvalid), .tready(tready), .timeout(timeout),
    .timeout_any(timeout_any), .first_vld(first_vld), .first_ch(first_ch),
    .stall_cnt(stall_cnt)
  );

  axis_stall_watchdog #(.NUM_CH(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .enable(s_enable), .limit(s_limit), .clear(s_clear),
    .tvalid(s_tvalid), .tready(s_tready), .timeout(s_timeout),
    .timeout_any(s_timeout_any), .first_vld(s_first_vld),
    .first_ch(s_first_ch), .stall_cnt(s_stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_tmo  = '0;
    m_frz  = '0;
    m_fvld = 1'b0;
    m_fch  = '0;
  endfunction

  // One clock edge of the reference model, using the inputs sampled at that edge.
  function automatic void modelStep(input logic en, input logic [31:0] lim,
                                    input logic [3:0] clr, input logic [3:0] v,
                                    input logic [3:0] r);
    logic [3:0] old_tmo;
    logic [3:0] rising;
    longint     max_cnt;
    longint     shown;
    max_cnt = 64'h0000_0000_FFFF_FFFF;
    old_tmo = m_tmo;
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) begin
        m_run[i] = 0;
        m_tmo[i] = 1'b0;
        m_frz[i] = 1'b0;
      end else if (!en) begin
        m_run[i] = 0;
        m_frz[i] = 1'b0;
      end else if (m_frz[i]) begin
        m_run[i] = m_run[i];
      end else if (v[i] && !r[i]) begin
        m_run[i] = m_run[i] + 1;
        shown = (m_run[i] > max_cnt) ? max_cnt : m_run[i];
        if (lim != 0 && shown == longint'(lim)) begin
          m_tmo[i] = 1'b1;
          m_frz[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    rising = m_tmo & ~old_tmo;
    if (m_fvld && old_tmo == 4'b0000) begin
      m_fvld = 1'b0;
      m_fch  = '0;
    end else if (!m_fvld && rising != 4'b0000) begin
      m_fvld = 1'b1;
      for (int i = 3; i >= 0; i--) if (rising[i]) m_fch = 2'(i);
    end
  endfunction

  function automatic exp_t modelExpected();
    exp_t e;
    e.tmo  = m_tmo;
    e.any  = |m_tmo;
    e.fvld = m_fvld;
    e.fch  = m_fch;
    for (int i = 0; i < 4; i++) e.cnt[i*32 +: 32] = m_run[i][31:0];
    return e;
  endfunction

  task automatic applyStimulus(input logic en, input logic [31:0] lim,
                               input logic [3:0] clr, input logic [3:0] v,
                               input logic [3:0] r);
    enable = en;
    limit  = lim;
    clear  = clr;
    tvalid = v;
    tready = r;
    @(posedge clk);
    #1;
    modelStep(en, lim, clr, v, r);
    sb_q.push_back(modelExpected());
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) checkOutput("scoreboard_drain", 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("timeout", 128'(timeout), 128'(e.tmo));
        checkOutput("timeout_any", 128'(timeout_any), 128'(e.any));
        checkOutput("first_vld", 128'(first_vld), 128'(e.fvld));
        checkOutput("first_ch", 128'(first_ch), 128'(e.fch));
        checkOutput("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [31:0] lim_tab [6];
    logic [31:0] cur_lim;
    lim_tab[0] = 0; lim_tab[1] = 1; lim_tab[2] = 2;
    lim_tab[3] = 3; lim_tab[4] = 5; lim_tab[5] = 8;

    rst = 1'b0;
    enable = 1'b1; limit = 32'd4; clear = '0; tvalid = '0; tready = '0;
    s_enable = 1'b1; s_limit = 4'd0; s_clear = '0; s_tvalid = '0; s_tready = '0;
    modelReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_timeout", 128'(timeout), 128'd0);
    checkOutput("reset_first_vld", 128'(first_vld), 128'd0);
    checkOutput("reset_cnt", stall_cnt, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] limit 4, channel 0 stalls four cycles");
    for (int i = 0; i < 4; i++) applyStimulus(1, 4, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("t1_timeout", 128'(timeout), 128'h1);
    checkOutput("t1_cnt0", 128'(stall_cnt[31:0]), 128'd4);
    checkOutput("t1_first_vld", 128'(first_vld), 128'd1);
    checkOutput("t1_first_ch", 128'(first_ch), 128'd0);
    applyStimulus(1, 4, 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(1, 4, 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] channel 1 breaks its stall before the limit");
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 4'b0000, 4'b0010, 4'b0000);
    checkOutput("t2_cnt1_run", 128'(stall_cnt[63:32]), 128'd3);
    applyStimulus(1, 4, 4'b0000, 4'b0010, 4'b0010);
    checkOutput("t2_cnt1_ready", 128'(stall_cnt[63:32]), 128'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(1, 4, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("t2_cnt1_novalid", 128'(stall_cnt[63:32]), 128'd0);
    checkOutput("t2_timeout", 128'(timeout), 128'd0);

    $display("[TB] channels 2 and 3 time out on the same edge");
    for (int i = 0; i < 8; i++) applyStimulus(1, 8, 4'b0000, 4'b1100, 4'b0000);
    checkOutput("t3_timeout", 128'(timeout), 128'hC);
    checkOutput("t3_first_ch", 128'(first_ch), 128'd2);
    applyStimulus(1, 8, 4'b0100, 4'b1000, 4'b0000);
    checkOutput("t3_clr2_timeout", 128'(timeout), 128'h8);
    checkOutput("t3_clr2_first_ch", 128'(first_ch), 128'd2);
    applyStimulus(1, 8, 4'b1000, 4'b0000, 4'b0000);
    checkOutput("t3_clr3_timeout", 128'(timeout), 128'd0);
    applyStimulus(1, 8, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("t3_first_vld_drop", 128'(first_vld), 128'd0);

    $display("[TB] limit 0 long stall and 4-bit saturation");
    for (int i = 0; i < 1000; i++) begin
      s_tvalid = (i < 20) ? 1'b1 : 1'b0;
      applyStimulus(1, 0, 4'b0000, 4'b0001, 4'b0000);
      if (i == 8) checkOutput("sat_cnt_mid", 128'(s_stall_cnt), 128'd9);
      if (i == 19) begin
        checkOutput("sat_cnt_hold", 128'(s_stall_cnt), 128'd15);
        checkOutput("sat_timeout", 128'(s_timeout), 128'd0);
      end
    end
    checkOutput("t4_cnt0", 128'(stall_cnt[31:0]), 128'd1000);
    checkOutput("t4_timeout", 128'(timeout), 128'd0);
    applyStimulus(1, 4, 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] clear racing a timeout, then enable low");
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(1, 4, 4'b0010, 4'b0010, 4'b0000);
    checkOutput("t5_clr_timeout", 128'(timeout), 128'd0);
    checkOutput("t5_clr_cnt1", 128'(stall_cnt[63:32]), 128'd0);
    applyStimulus(1, 4, 4'b0000, 4'b0010, 4'b0000);
    checkOutput("t5_restart_cnt1", 128'(stall_cnt[63:32]), 128'd1);
    applyStimulus(1, 4, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(1, 4, 4'b0000, 4'b0001, 4'b0000);
    applyStimulus(0, 4, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("t5_dis_timeout", 128'(timeout), 128'h1);
    checkOutput("t5_dis_cnt0", 128'(stall_cnt[31:0]), 128'd0);
    applyStimulus(1, 4, 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(1, 4, 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] asynchronous reset mid-stall with a flag set");
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 8, 4'b0000, (i < 3) ? 4'b0010 : 4'b0011, 4'b0000);
    checkOutput("t6_pre_cnt0", 128'(stall_cnt[31:0]), 128'd5);
    checkOutput("t6_pre_timeout", 128'(timeout), 128'h2);
    waitDrain();
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_timeout", 128'(timeout), 128'd0);
    checkOutput("t6_rst_any", 128'(timeout_any), 128'd0);
    checkOutput("t6_rst_first_vld", 128'(first_vld), 128'd0);
    checkOutput("t6_rst_cnt", stall_cnt, 128'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1, 8, 4'b0000, 4'b0011, 4'b0000);
    checkOutput("t6_post_no_timeout", 128'(timeout), 128'd0);
    applyStimulus(1, 8, 4'b0000, 4'b0011, 4'b0000);
    checkOutput("t6_post_timeout", 128'(timeout), 128'h3);
    checkOutput("t6_post_first_ch", 128'(first_ch), 128'd0);
    applyStimulus(1, 8, 4'b1111, 4'b0000, 4'b0000);

    $display("[TB] randomized traffic");
    cur_lim = 32'd3;
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] v;
      logic [3:0] r;
      logic [3:0] c;
      if ($urandom_range(0, 49) == 0) cur_lim = lim_tab[$urandom_range(0, 5)];
      for (int k = 0; k < 4; k++) begin
        v[k] = ($urandom_range(0, 9) < 7);
        r[k] = ($urandom_range(0, 9) < 3);
        c[k] = ($urandom_range(0, 39) == 0);
      end
      applyStimulus(($urandom_range(0, 19) != 0), cur_lim, c, v, r);
    end
    applyStimulus(1, 0, 4'b0000, 4'b0000, 4'b0000);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
